// File: rtl/user_fifo_stream_ctrl.sv
// FWFT stream FIFO controller for an external dual-port RAM: the sink writes the RAM and a
// small skid FIFO prefetches RAM words so the source side runs at one word per clock.
module user_fifo_stream_ctrl #(
  parameter int    DATA_WIDTH = 8,
  parameter int    ADDR_WIDTH = 9,
  parameter string OUTPUT_REG = "TRUE"
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram_re,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic [ADDR_WIDTH+1:0] count,
  output logic                  full,
  output logic                  empty
);

  localparam int RD_LAT = (OUTPUT_REG == "TRUE") ? 2 : 1;
  localparam int SKID   = RD_LAT + 1;
  localparam int SW     = $clog2(SKID);
  localparam int UW     = ADDR_WIDTH + 1;
  localparam int CW     = ADDR_WIDTH + 2;

  localparam logic [UW-1:0] DEPTH_U   = UW'(1 << ADDR_WIDTH);
  localparam logic [SW-1:0] SKID_LAST = SW'(SKID - 1);
  localparam logic [2:0]    SKID_N    = 3'(SKID);

  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
  logic [UW-1:0]         ram_used_q, ram_used_d;
  logic                  push_q, push_d;
  logic                  s_ready_q, s_ready_d;
  logic [RD_LAT-1:0]     tag_q, tag_d;
  logic [DATA_WIDTH-1:0] skid_mem_q [SKID];
  logic [DATA_WIDTH-1:0] skid_mem_d [SKID];
  logic [SW-1:0]         head_q, head_d;
  logic [SW-1:0]         tail_q, tail_d;
  logic [2:0]            skid_occ_q, skid_occ_d;
  logic                  m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic [CW-1:0]         count_q, count_d;

  logic       push;
  logic       pop;
  logic       cap;
  logic       rd_en;
  logic [2:0] inflight;
  logic [3:0] pending;

  function automatic logic [SW-1:0] skid_next(input logic [SW-1:0] p);
    return (p == SKID_LAST) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    push = s_valid & s_ready_q;
    pop  = m_valid_q & m_ready;
    cap  = tag_q[RD_LAT-1];

    inflight = '0;
    for (int unsigned i = 0; i < RD_LAT; i++) begin
      inflight = inflight + 3'(tag_q[i]);
    end
    pending = {1'b0, skid_occ_q} + {1'b0, inflight} - {3'b000, pop};

    // A word written at the previous edge is held back one cycle, so a read never
    // races the write to the same address.
    rd_en = (ram_used_q > {{ADDR_WIDTH{1'b0}}, push_q}) && (pending < {1'b0, SKID_N});

    wptr_d     = push  ? wptr_q + 1'b1 : wptr_q;
    rptr_d     = rd_en ? rptr_q + 1'b1 : rptr_q;
    ram_used_d = ram_used_q + UW'(push) - UW'(rd_en);
    push_d     = push;
    s_ready_d  = (ram_used_q + UW'(push)) < DEPTH_U;

    tag_d    = '0;
    tag_d[0] = rd_en;
    for (int unsigned i = 1; i < RD_LAT; i++) begin
      tag_d[i] = tag_q[i-1];
    end

    skid_mem_d = skid_mem_q;
    if (cap) begin
      skid_mem_d[tail_q] = ram_rdata;
    end
    tail_d     = cap ? skid_next(tail_q) : tail_q;
    head_d     = pop ? skid_next(head_q) : head_q;
    skid_occ_d = skid_occ_q + {2'b00, cap} - {2'b00, pop};
    m_valid_d  = (skid_occ_d != '0);

    // Reading the next-state array lets a capture into an empty skid reach m_data directly.
    m_data_d = m_data_q;
    if (skid_occ_d != '0) begin
      m_data_d = skid_mem_d[head_d];
    end

    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      ram_used_q <= '0;
      push_q     <= 1'b0;
      s_ready_q  <= 1'b1;
      tag_q      <= '0;
      for (int unsigned i = 0; i < SKID; i++) begin
        skid_mem_q[i] <= '0;
      end
      head_q     <= '0;
      tail_q     <= '0;
      skid_occ_q <= '0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      count_q    <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      ram_used_q <= ram_used_d;
      push_q     <= push_d;
      s_ready_q  <= s_ready_d;
      tag_q      <= tag_d;
      skid_mem_q <= skid_mem_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      skid_occ_q <= skid_occ_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      count_q    <= count_d;
    end
  end

  assign s_ready   = s_ready_q;
  assign full      = ~s_ready_q;
  assign m_valid   = m_valid_q;
  assign empty     = ~m_valid_q;
  assign m_data    = m_data_q;
  assign ram_we    = push;
  assign ram_waddr = wptr_q;
  assign ram_wdata = s_data;
  assign ram_re    = rd_en;
  assign ram_raddr = rptr_q;
  assign count     = count_q;

  skid_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
    !(cap && !pop && (skid_occ_q == SKID_N)));

endmodule
